// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// every datapath select and enable, and guards memory waits with a watchdog.
// Optional feature macro: MIPS_CTRL_TRAP_EN (illegal opcode/funct halts the
// core and raises illegal_op; otherwise illegal encodings retire as NOPs).
module mips_ctrl_fsm #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ior,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_ctl,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       instr_done,
  output logic       halted,
  output logic       mem_timeout,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_MEM_ADDR, S_MEM_READ,
    S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_I_EXEC, S_I_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wait counter value seen in the last permitted cycle of a memory state.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

`ifdef MIPS_CTRL_TRAP_EN
  localparam state_t S_ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t S_ILLEGAL_NEXT = S_FETCH;
`endif

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       halted_q, halted_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       op_legal, fn_legal, is_mem_state, mem_expire;
  logic       pc_write, pc_write_cond;

  // Instruction legality and watchdog expiry for the current cycle.
  always_comb begin
    op_legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                              OP_ADDI, OP_ANDI, OP_ORI};
    fn_legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    is_mem_state = state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    mem_expire   = is_mem_state && !mem_ready && (wait_cnt_q == WAIT_LAST);
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
                   else if (mem_expire) state_d = S_HALT;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:               state_d = S_R_EXEC;
          OP_LW, OP_SW:           state_d = S_MEM_ADDR;
          OP_BEQ:                 state_d = S_BRANCH;
          OP_J:                   state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
          default:                state_d = S_ILLEGAL_NEXT;
        endcase
      end
      S_R_EXEC:    state_d = fn_legal ? S_R_WB : S_ILLEGAL_NEXT;
      S_R_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
                   else if (mem_expire) state_d = S_HALT;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
                   else if (mem_expire) state_d = S_HALT;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the state (ext_sel idles at sign-extend).
  always_comb begin
    ior           = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_sel       = 1'b1;
    alu_ctl       = 3'b000;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    unique case (state_q)
      S_IDLE: ext_sel = 1'b0;
      S_FETCH: begin
        mem_read  = !mem_expire;
        alu_src_b = 2'b01;
        alu_ctl   = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctl   = ALU_ADD;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        unique case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: alu_ctl = 3'b000;
        endcase
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctl   = ALU_ADD;
      end
      S_MEM_READ: begin
        ior      = 1'b1;
        mem_read = !mem_expire;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ior       = 1'b1;
        mem_write = !mem_expire;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctl       = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_ANDI: begin ext_sel = 1'b0; alu_ctl = ALU_AND; end
          OP_ORI:  begin ext_sel = 1'b0; alu_ctl = ALU_OR;  end
          default: alu_ctl = ALU_ADD;
        endcase
      end
      S_I_WB: reg_write = 1'b1;
      default: ;
    endcase
    pc_en      = pc_write | (pc_write_cond & zero);
    instr_done = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH);
  end

  // Watchdog counter and sticky status flags, next values.
  always_comb begin
    if (state_d != state_q)
      wait_cnt_d = '0;
    else if (is_mem_state && !mem_ready)
      wait_cnt_d = wait_cnt_q + 8'd1;
    else
      wait_cnt_d = wait_cnt_q;
    halted_d      = halted_q | (state_d == S_HALT);
    mem_timeout_d = mem_timeout_q | mem_expire;
  end

  // State, watchdog and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;

`ifdef MIPS_CTRL_TRAP_EN
  logic illegal_op_q, illegal_hit;

  // Flags a trap raised by an unknown opcode in DECODE or funct in R_EXEC.
  always_comb begin
    illegal_hit = ((state_q == S_DECODE) && !op_legal) ||
                  ((state_q == S_R_EXEC) && !fn_legal);
  end

  // Sticky illegal-instruction flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_op_q <= 1'b0;
    else       illegal_op_q <= illegal_op_q | illegal_hit;
  end

  assign illegal_op = illegal_op_q;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized bench for mips_ctrl_fsm: each instruction is expanded into the
// list of cycles it should take (with its memory waits) and the controls each
// of those cycles must show, then the DUT is stepped against that list.
module tb_mips_ctrl_fsm;
  localparam int unsigned WMAX = 4;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       ior, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, ext_sel, pc_en, instr_done, halted, mem_timeout, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctl;

  mips_ctrl_fsm #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ior(ior), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .alu_ctl(alu_ctl), .pc_source(pc_source), .pc_en(pc_en),
    .instr_done(instr_done), .halted(halted), .mem_timeout(mem_timeout),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       ior, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [2:0] alu_ctl;
    logic [1:0] pc_source;
    logic       pc_en, instr_done, halted, mem_timeout, illegal_op;
  } outv_t;

  outv_t got_v;
  assign got_v = {ior, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, ext_sel, alu_ctl, pc_source, pc_en, instr_done,
                  halted, mem_timeout, illegal_op};

  outv_t exp_q[$];
  string tag_q[$];
  logic  rdy_q[$];
  logic  zro_q[$];

  int unsigned checks, failures;
  logic m_halt, m_tmo, m_ill;
  int   beq_force;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outv_t base();
    outv_t o;
    o = '0;
    o.ext_sel     = 1'b1;
    o.halted      = m_halt;
    o.mem_timeout = m_tmo;
    o.illegal_op  = m_ill;
    return o;
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101};
  endfunction

  task automatic push(input string tag, input outv_t o, input logic rdy, input logic z);
    tag_q.push_back(tag);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
    zro_q.push_back(z);
  endtask

  task automatic push_halt(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) push("HALT", base(), rb(), rb());
  endtask

  // kind 0 = instruction fetch, 1 = load read, 2 = store write.
  // The memory answers after `waits` low cycles; WMAX low cycles is a timeout.
  task automatic mem_phase(input int kind, input int unsigned waits, output logic ok);
    outv_t o;
    logic  last;
    string nm;
    nm = (kind == 0) ? "FETCH" : (kind == 1) ? "MEM_READ" : "MEM_WRITE";
    for (int unsigned i = 0; i <= waits && i < WMAX; i++) begin
      last = (i == waits);
      o = base();
      if (kind == 0) begin
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'b01;
        o.alu_ctl   = 3'b010;
        o.ir_write  = last;
        o.pc_en     = last;
      end else begin
        o.ior        = 1'b1;
        o.mem_read   = (kind == 1);
        o.mem_write  = (kind == 2);
        o.instr_done = (kind == 2) && last;
      end
      if (!last && i == WMAX - 1) begin
        o.mem_read  = 1'b0;
        o.mem_write = 1'b0;
      end
      push(nm, o, last, rb());
    end
    ok = (waits < WMAX);
    if (!ok) begin
      m_halt = 1'b1;
      m_tmo  = 1'b1;
    end
  endtask

  task automatic illegal_end(input string tag, input outv_t o, output logic h);
`ifdef MIPS_CTRL_TRAP_EN
    push(tag, o, rb(), rb());
    m_halt = 1'b1;
    m_ill  = 1'b1;
    push_halt(3);
    h = 1'b1;
`else
    o.instr_done = 1'b1;
    push(tag, o, rb(), rb());
    h = 1'b0;
`endif
  endtask

  task automatic build_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int unsigned wf, input int unsigned wm, output logic h);
    outv_t o;
    logic  ok, z;
    h = 1'b0;
    mem_phase(0, wf, ok);
    if (!ok) begin push_halt(3); h = 1'b1; return; end
    o = base();
    o.alu_src_b = 2'b11;
    o.alu_ctl   = 3'b010;
    if (!op_known(op)) begin illegal_end("DECODE", o, h); return; end
    push("DECODE", o, rb(), rb());
    o = base();
    case (op)
      6'b000000: begin
        o.alu_src_a = 1'b1;
        case (fn)
          6'b100000: o.alu_ctl = 3'b010;
          6'b100010: o.alu_ctl = 3'b110;
          6'b100100: o.alu_ctl = 3'b000;
          6'b100101: o.alu_ctl = 3'b001;
          6'b101010: o.alu_ctl = 3'b111;
          default: begin illegal_end("R_EXEC", o, h); return; end
        endcase
        push("R_EXEC", o, rb(), rb());
        o = base(); o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
        push("R_WB", o, rb(), rb());
      end
      6'b100011, 6'b101011: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctl = 3'b010;
        push("MEM_ADDR", o, rb(), rb());
        mem_phase((op == 6'b100011) ? 1 : 2, wm, ok);
        if (!ok) begin push_halt(3); h = 1'b1; return; end
        if (op == 6'b100011) begin
          o = base(); o.mem_to_reg = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
          push("MEM_WB", o, rb(), rb());
        end
      end
      6'b000100: begin
        z = (beq_force < 0) ? rb() : beq_force[0];
        o.alu_src_a = 1'b1; o.alu_ctl = 3'b110; o.pc_source = 2'b01;
        o.pc_en = z; o.instr_done = 1'b1;
        push("BRANCH", o, rb(), z);
      end
      6'b000010: begin
        o.pc_source = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
        push("JUMP", o, rb(), rb());
      end
      default: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        if (op == 6'b001100)      begin o.ext_sel = 1'b0; o.alu_ctl = 3'b000; end
        else if (op == 6'b001101) begin o.ext_sel = 1'b0; o.alu_ctl = 3'b001; end
        else                      o.alu_ctl = 3'b010;
        push("I_EXEC", o, rb(), rb());
        o = base(); o.reg_write = 1'b1; o.instr_done = 1'b1;
        push("I_WB", o, rb(), rb());
      end
    endcase
  endtask

  // Steps the DUT through up to n queued cycles; entered and left at posedge+1.
  task automatic run_n(input int unsigned n);
    outv_t e;
    string t;
    for (int unsigned i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      mem_ready = rdy_q.pop_front();
      zero      = zro_q.pop_front();
      @(negedge clk);
      chk(t, 32'(got_v), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_q();
    exp_q.delete(); tag_q.delete(); rdy_q.delete(); zro_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_async", 32'(got_v), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 32'(got_v), 32'd0);
    reset  = 1'b0;
    m_halt = 1'b0;
    m_tmo  = 1'b0;
    m_ill  = 1'b0;
    push("IDLE", '0, rb(), rb());
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input int unsigned wf, input int unsigned wm);
    logic h;
    opcode = op;
    funct  = fn;
    build_instr(op, fn, wf, wm, h);
    run_n(exp_q.size());
    if (h) do_reset();
  endtask

  function automatic int unsigned rnd_wait();
    return ($urandom_range(0, 15) == 0) ? WMAX : $urandom_range(0, WMAX - 1);
  endfunction

  initial begin
    logic [5:0] op, fn;
    logic [5:0] fns [5];
    logic       h;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    checks = 0; failures = 0; beq_force = -1;
    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    m_halt = 1'b0; m_tmo = 1'b0; m_ill = 1'b0;
    #2;
    do_reset();

    do_instr(6'b000000, 6'b100000, 0, 0);      // R-type add, no waits
    do_instr(6'b100011, 6'b000000, 0, 2);      // lw, two read wait cycles
    do_instr(6'b101011, 6'b000000, 1, 3);      // sw, answer in last allowed cycle
    beq_force = 1;
    do_instr(6'b000100, 6'b000000, 0, 0);
    beq_force = 0;
    do_instr(6'b000100, 6'b000000, 0, 0);
    beq_force = -1;
    do_instr(6'b000010, 6'b000000, 0, 0);
    do_instr(6'b001100, 6'b000000, 0, 0);
    do_instr(6'b001000, 6'b000000, WMAX - 1, 0); // fetch ready in cycle WMAX
    do_instr(6'b001101, 6'b000000, WMAX, 0);     // fetch timeout
    do_instr(6'b111111, 6'b000000, 0, 0);        // illegal opcode
    do_instr(6'b000000, 6'b111111, 0, 0);        // illegal funct
    do_instr(6'b100011, 6'b000000, 0, WMAX);     // read timeout

    // Reset asynchronously while a load is waiting in MEM_READ.
    opcode = 6'b100011;
    build_instr(6'b100011, 6'b000000, 0, 3, h);
    run_n(5);
    mem_ready = 1'b0;
    #1;
    chk("mid_read_ior", 32'(ior), 32'd1);
    flush_q();
    do_reset();

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 8:    op = 6'b000000;
        1:       op = 6'b100011;
        2:       op = 6'b101011;
        3:       op = 6'b000100;
        4:       op = 6'b000010;
        5:       op = 6'b001000;
        6:       op = 6'b001100;
        7:       op = 6'b001101;
        default: begin
          op = 6'($urandom);
          while (op_known(op)) op = 6'($urandom);
        end
      endcase
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      do_instr(op, fn, rnd_wait(), rnd_wait());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL sim_time_limit got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multicycle control unit for the MIPS core datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives every datapath select: ALU source A/B muxes, sign/zero-extend select, ALU function, PC source, and memory and register-file enables. Memory accesses use a ready handshake with a watchdog, and illegal opcodes are handled optionally.

## Interface
- `MEM_WAIT_MAX`, 15: maximum cycles a memory state waits for `mem_ready`. Legal range 1..255.
- `clk` in 1: clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces state IDLE and clears all counters and flags.
- `opcode` in 6: IR[31:26], stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `ior` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write`, `ir_write`, `reg_write` out 1 each: enables.
- `reg_dst` out 1: write register select (0 = rt, 1 = rd).
- `mem_to_reg` out 1: write data select (0 = ALUOut, 1 = MDR).
- `alu_src_a` out 1: ALU A select (0 = PC, 1 = reg A).
- `alu_src_b` out 2: ALU B select (00 = reg B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2).
- `ext_sel` out 1: immediate extender mode (1 = sign, 0 = zero).
- `alu_ctl` out 3: ALU function (010 add, 110 sub, 000 and, 001 or, 111 slt).
- `pc_source` out 2: PC source (00 = ALU, 01 = ALUOut, 10 = jump target).
- `pc_en` out 1: PC load, equal to `pc_write | (pc_write_cond & zero)`.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `halted`, `mem_timeout`, `illegal_op` out 1 each: status flags, sticky until reset.

## Operation
- Outputs are decoded from the state, plus `opcode`/`funct`/`mem_ready` where noted. Any output not listed for a state is 0, except `ext_sel`, which defaults to 1.
- **IDLE**: all outputs 0. Goes to FETCH on the next edge. This is the reset state, so every output reads 0 during and directly after reset.
- **FETCH**:
  - Drives `mem_read=1`, `ior=0`, `alu_src_a=0`, `alu_src_b=01`, `alu_ctl=010`, `pc_source=00`.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Goes to DECODE when `mem_ready` is high.
- **DECODE**: drives `alu_src_a=0`, `alu_src_b=11`, add. Next state by `opcode`:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000, 001100, 001101 → I_EXEC
  - any other value → ILLEGAL handling
- **R_EXEC**:
  - Drives `alu_src_a=1`, `alu_src_b=00`.
  - `alu_ctl` by funct: 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Goes to R_WB. Any other funct is ILLEGAL.
- **R_WB**: drives `reg_dst=1`, `reg_write=1`. Goes to FETCH.
- **MEM_ADDR**: drives `alu_src_a=1`, `alu_src_b=10`, `ext_sel=1`, add. Goes to MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ**: drives `ior=1`, `mem_read=1`. Goes to MEM_WB on `mem_ready`.
- **MEM_WB**: drives `mem_to_reg=1`, `reg_write=1`. Goes to FETCH.
- **MEM_WRITE**: drives `ior=1`, `mem_write=1`. Goes to FETCH on `mem_ready`.
- **BRANCH**: drives `alu_src_a=1`, `alu_src_b=00`, sub, `pc_write_cond=1`, `pc_source=01`. Goes to FETCH.
- **JUMP**: drives `pc_write=1`, `pc_source=10`. Goes to FETCH.
- **I_EXEC**:
  - Drives `alu_src_a=1`, `alu_src_b=10`.
  - addi: `ext_sel=1`, add. andi: `ext_sel=0`, and. ori: `ext_sel=0`, or.
  - Goes to I_WB.
- **I_WB**: drives `reg_dst=0`, `reg_write=1`. Goes to FETCH.
- **HALT**: all enables 0, `halted=1`. Leaves only on reset.
- **instr_done**: pulses in the final cycle of each instruction, i.e. whenever the next state is FETCH from a non-IDLE state.
- **Watchdog**:
  - An 8-bit wait counter clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - It increments each cycle in one of those states while `mem_ready=0`.
  - If `mem_ready` is low in all of the first `MEM_WAIT_MAX` cycles of the state, the next edge goes to HALT and sets `mem_timeout`. No enable is asserted in that cycle.

## Timing
- Cycles per instruction with zero-wait memory:
  - R-type and I-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
- Each wait cycle adds one cycle.
- `mem_ready` is sampled on the same edge that commits the transition. `ir_write`/`pc_en` in FETCH are combinational on `mem_ready`.
- If `mem_ready` rises in cycle `MEM_WAIT_MAX` itself, the access completes normally with no timeout.
- Reset asserted mid-instruction, including mid-wait: state goes to IDLE immediately (asynchronously) and all outputs go to 0. No partial write is issued after reset release.

## Configuration
- `MIPS_CTRL_TRAP_EN` defined: an illegal opcode or funct goes to HALT and sets `illegal_op=1`.
- Undefined: an illegal opcode or funct is treated as a NOP. The FSM returns to FETCH with `instr_done` pulsed, and `illegal_op` is tied to 0.

## Test plan
- **Reset**: reset asserted mid-MEM_READ → all outputs 0 at once. After release, IDLE lasts 1 cycle, then FETCH with `mem_read=1`.
- **R-type add**: opcode 000000, funct 100000, `mem_ready` always 1 → 4 cycles. `alu_ctl=010` in R_EXEC, `reg_dst=1` and `reg_write=1` in R_WB, one `instr_done` pulse.
- **lw with wait**: lw with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles total. `ior=1` throughout MEM_READ, `mem_to_reg=1` in MEM_WB.
- **beq**: beq with `zero=1` → `pc_en=1` and `pc_source=01` in BRANCH. With `zero=0` → `pc_en=0`.
- **Watchdog** (`MEM_WAIT_MAX=4`):
  - `mem_ready` low for 4 FETCH cycles → HALT with `mem_timeout=1` and `halted=1`.
  - `mem_ready` high in the 4th cycle instead → normal entry to DECODE.
- **Illegal opcode**: opcode 111111 → with `MIPS_CTRL_TRAP_EN`, HALT with `illegal_op=1`. Without it, back to FETCH after DECODE with `instr_done=1`.
